// File: rtl/shootout_pkg.sv
// Shared types and constants for the penalty shootout game controller.
// The state encoding here is the game_state encoding used by color_mapper and the HUD.
package shootout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_FLIGHT = 3'd2,
    ST_RESULT = 3'd3,
    ST_OVER   = 3'd4
  } shootout_state_t;

  localparam logic [7:0] KEY_ENTER    = 8'h28;
  localparam int         GAME_STATE_W = 3;

  // True when any of the four USB keycode bytes carries the given code.
  function automatic logic has_key(input logic [31:0] keys, input logic [7:0] code);
    return (keys[7:0] == code) || (keys[15:8] == code) ||
           (keys[23:16] == code) || (keys[31:24] == code);
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/penalty_shootout_fsm_rise_detect.sv
// Registered rising-edge detector. The first sample after reset only loads the
// history register, so a level that is already high at release is not an edge.
module rise_detect #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_al,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rise;
  logic             r_armed;

  always_ff @(posedge i_clk) begin
    if (!i_reset_al) begin
      r_prev  <= '0;
      r_rise  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_d;
      r_armed <= 1'b1;
      r_rise  <= i_d & ~r_prev & {WIDTH{r_armed}};
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/penalty_shootout_fsm.sv
// Best-of-N penalty shootout controller: start, kick, save/goal resolution,
// result hold and early termination. All outputs come straight from flops.
module penalty_shootout_fsm
  import shootout_pkg::*;
#(
  parameter int NUM_KICKS     = 5,
  parameter int FLIGHT_FRAMES = 30,
  parameter int RESULT_FRAMES = 60
) (
  input  logic        clk_25MHz,
  input  logic        reset_al,
  input  logic        vsync,
  input  logic [31:0] keycode,
  input  logic        player_at_ball_signal,
  input  logic        save_detect,
  output logic [2:0]  game_state,
  output logic [3:0]  goals,
  output logic [3:0]  saves,
  output logic [3:0]  kick_num,
  output logic        last_was_goal,
  output logic        kick_active,
  output logic        respawn,
  output logic        game_over,
  output logic        shooter_wins
);

  localparam int CNT_W = $clog2(max_int(FLIGHT_FRAMES, RESULT_FRAMES) + 1);
  localparam logic [CNT_W-1:0] FLIGHT_LAST = CNT_W'(FLIGHT_FRAMES - 1);
  localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_FRAMES - 1);
  localparam logic [3:0]       KICKS_4     = 4'(NUM_KICKS);
  localparam logic [3:0]       HALF_4      = 4'(NUM_KICKS / 2);

  // Event pulses, each one cycle and one cycle late relative to its input.
  logic w_enter_lvl;
  logic w_enter;
  logic w_frame_tick;
  logic w_kick;

  assign w_enter_lvl = has_key(keycode, KEY_ENTER);

  rise_detect #(.WIDTH(1)) u_rise_vsync (
    .i_clk      (clk_25MHz),
    .i_reset_al (reset_al),
    .i_d        (vsync),
    .o_rise     (w_frame_tick)
  );

  rise_detect #(.WIDTH(1)) u_rise_enter (
    .i_clk      (clk_25MHz),
    .i_reset_al (reset_al),
    .i_d        (w_enter_lvl),
    .o_rise     (w_enter)
  );

  rise_detect #(.WIDTH(1)) u_rise_kick (
    .i_clk      (clk_25MHz),
    .i_reset_al (reset_al),
    .i_d        (player_at_ball_signal),
    .o_rise     (w_kick)
  );

  shootout_state_t  r_state, w_state_next;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_next;
  logic [3:0]       r_goals, w_goals_next;
  logic [3:0]       r_saves, w_saves_next;
  logic [3:0]       r_kick_num, w_kick_num_next;
  logic             r_last_goal, w_last_goal_next;
  logic             r_respawn, r_kick_active, r_game_over, r_shooter_wins;
  logic             w_game_done;

  // Early termination uses the scores already updated on RESULT entry.
  assign w_game_done = (r_kick_num == KICKS_4) || (r_goals > HALF_4) || (r_saves > HALF_4);

  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    w_goals_next     = r_goals;
    w_saves_next     = r_saves;
    w_kick_num_next  = r_kick_num;
    w_last_goal_next = r_last_goal;

    case (r_state)
      ST_IDLE: begin
        w_frame_cnt_next = '0;
        w_goals_next     = '0;
        w_saves_next     = '0;
        w_kick_num_next  = '0;
        w_last_goal_next = 1'b0;
        if (w_enter) w_state_next = ST_READY;
      end
      ST_READY: begin
        w_frame_cnt_next = '0;
        if (w_kick) w_state_next = ST_FLIGHT;
      end
      ST_FLIGHT: begin
        if (w_frame_tick) w_frame_cnt_next = r_frame_cnt + CNT_W'(1);
        // A save beats a timeout landing on the same cycle.
        if (save_detect) begin
          w_saves_next     = sat_inc4(r_saves);
          w_kick_num_next  = sat_inc4(r_kick_num);
          w_last_goal_next = 1'b0;
          w_frame_cnt_next = '0;
          w_state_next     = ST_RESULT;
        end else if (w_frame_tick && (r_frame_cnt == FLIGHT_LAST)) begin
          w_goals_next     = sat_inc4(r_goals);
          w_kick_num_next  = sat_inc4(r_kick_num);
          w_last_goal_next = 1'b1;
          w_frame_cnt_next = '0;
          w_state_next     = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (w_frame_tick) begin
          if (r_frame_cnt == RESULT_LAST) begin
            w_frame_cnt_next = '0;
            w_state_next     = w_game_done ? ST_OVER : ST_READY;
          end else begin
            w_frame_cnt_next = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      ST_OVER: begin
        // Scores clear on the way out so IDLE never shows a stale result.
        if (w_enter) begin
          w_state_next     = ST_IDLE;
          w_goals_next     = '0;
          w_saves_next     = '0;
          w_kick_num_next  = '0;
          w_last_goal_next = 1'b0;
        end
      end
      default: begin
        w_state_next     = ST_IDLE;
        w_frame_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (!reset_al) begin
      r_state        <= ST_IDLE;
      r_frame_cnt    <= '0;
      r_goals        <= '0;
      r_saves        <= '0;
      r_kick_num     <= '0;
      r_last_goal    <= 1'b0;
      r_respawn      <= 1'b0;
      r_kick_active  <= 1'b0;
      r_game_over    <= 1'b0;
      r_shooter_wins <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_frame_cnt    <= w_frame_cnt_next;
      r_goals        <= w_goals_next;
      r_saves        <= w_saves_next;
      r_kick_num     <= w_kick_num_next;
      r_last_goal    <= w_last_goal_next;
      r_respawn      <= (w_state_next == ST_READY) && (r_state != ST_READY);
      r_kick_active  <= (w_state_next == ST_FLIGHT);
      r_game_over    <= (w_state_next == ST_OVER);
      r_shooter_wins <= (w_state_next == ST_OVER) && (w_goals_next > w_saves_next);
    end
  end

  assign game_state    = r_state;
  assign goals         = r_goals;
  assign saves         = r_saves;
  assign kick_num      = r_kick_num;
  assign last_was_goal = r_last_goal;
  assign kick_active   = r_kick_active;
  assign respawn       = r_respawn;
  assign game_over     = r_game_over;
  assign shooter_wins  = r_shooter_wins;

endmodule

// File: tb/tb_penalty_shootout_fsm.sv
// Scoreboard bench for penalty_shootout_fsm: every state transition is checked
// against a hand-computed snapshot queued by the driver.
module tb_penalty_shootout_fsm;

  localparam int W = 20;

  logic        clk_25MHz = 1'b0;
  logic        reset_al;
  logic        vsync;
  logic [31:0] keycode;
  logic        player_at_ball_signal;
  logic        save_detect;
  logic [2:0]  game_state;
  logic [3:0]  goals, saves, kick_num;
  logic        last_was_goal, kick_active, respawn, game_over, shooter_wins;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  always #20 clk_25MHz = ~clk_25MHz;

  penalty_shootout_fsm #(
    .NUM_KICKS     (5),
    .FLIGHT_FRAMES (30),
    .RESULT_FRAMES (60)
  ) dut (
    .clk_25MHz             (clk_25MHz),
    .reset_al              (reset_al),
    .vsync                 (vsync),
    .keycode               (keycode),
    .player_at_ball_signal (player_at_ball_signal),
    .save_detect           (save_detect),
    .game_state            (game_state),
    .goals                 (goals),
    .saves                 (saves),
    .kick_num              (kick_num),
    .last_was_goal         (last_was_goal),
    .kick_active           (kick_active),
    .respawn               (respawn),
    .game_over             (game_over),
    .shooter_wins          (shooter_wins)
  );

  // Snapshot layout: state, goals, saves, kick_num, last, kick_active, over, wins, respawn.
  function automatic logic [W-1:0] mk(input int st, input int g, input int s, input int k,
                                      input bit last, input bit ka, input bit ov,
                                      input bit win, input bit rs);
    return {3'(st), 4'(g), 4'(s), 4'(k), last, ka, ov, win, rs};
  endfunction

  // last_was_goal only means something in RESULT, shooter_wins only in OVER.
  function automatic logic [W-1:0] snap();
    logic l, w;
    l = (game_state == 3'd3) ? last_was_goal : 1'b0;
    w = (game_state == 3'd4) ? shooter_wins : 1'b0;
    return {game_state, goals, saves, kick_num, l, kick_active, game_over, w, respawn};
  endfunction

  task automatic exp_idle();                        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); endtask
  task automatic exp_ready(input int g, s, k);      exp_q.push_back(mk(1, g, s, k, 0, 0, 0, 0, 1)); endtask
  task automatic exp_flight(input int g, s, k);     exp_q.push_back(mk(2, g, s, k, 0, 1, 0, 0, 0)); endtask
  task automatic exp_result(input int g, s, k, input bit l); exp_q.push_back(mk(3, g, s, k, l, 0, 0, 0, 0)); endtask
  task automatic exp_over(input int g, s, k, input bit w);   exp_q.push_back(mk(4, g, s, k, 0, 0, 1, w, 0)); endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic monitor_loop();
    logic [2:0]   prev;
    logic [W-1:0] act, e;
    int           n;
    prev = 3'd0;
    n = 0;
    forever begin
      @(negedge clk_25MHz);
      if (mon_en) begin
        act = snap();
        if (game_state != prev) begin
          n++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL transition%0d: got %h required nothing queued", n, act);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              failures++;
              $display("FAIL transition%0d: got %h required %h", n, act, e);
            end
          end
        end else if (respawn) begin
          checks++;
          failures++;
          $display("FAIL respawn_stray: got 1 required 0 (state %0d)", game_state);
        end
        prev = game_state;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_25MHz);
  endtask

  // One vsync pulse; on return the frame tick has been acted on.
  task automatic frame(input bit save_on_tick);
    @(negedge clk_25MHz); vsync = 1'b1;
    @(negedge clk_25MHz); vsync = 1'b0; save_detect = save_on_tick;
    @(negedge clk_25MHz); save_detect = 1'b0;
    @(negedge clk_25MHz);
  endtask

  task automatic frames(input int n);
    repeat (n) frame(1'b0);
  endtask

  task automatic press(input logic [31:0] key);
    @(negedge clk_25MHz); keycode = key;
    @(negedge clk_25MHz); keycode = '0;
    @(negedge clk_25MHz);
  endtask

  task automatic kick(input bit hold);
    @(negedge clk_25MHz); player_at_ball_signal = 1'b1;
    @(negedge clk_25MHz); if (!hold) player_at_ball_signal = 1'b0;
    @(negedge clk_25MHz);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_25MHz); reset_al = 1'b0;
    cycles(n);
    reset_al = 1'b1;
    cycles(3);
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    reset_al = 1'b0;
    vsync = 1'b0;
    keycode = '0;
    player_at_ball_signal = 1'b0;
    save_detect = 1'b0;

    fork
      monitor_loop();
      begin
        repeat (30000) @(posedge clk_25MHz);
        failures++;
        $display("FAIL watchdog: got timeout required completion");
        finish_run();
      end
    join_none

    // Reset held for 5 cycles: everything zero, IDLE.
    cycles(5);
    check("reset_outputs", 32'(snap()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    check("reset_raw_flags", {28'd0, last_was_goal, shooter_wins, game_over, respawn}, 32'd0);
    reset_al = 1'b1;
    cycles(3);
    mon_en = 1'b1;

    // Game 1: start, then save_detect while READY is ignored.
    exp_ready(0, 0, 0);
    press(32'h0000_0028);
    check("start_ready", 32'(game_state), 32'd1);
    save_detect = 1'b1; cycles(3); save_detect = 1'b0; cycles(2);
    check("ready_save_ignored", {24'd0, goals, saves}, 32'd0);

    // Kick 1: goal on the 30th tick; Enter (top byte) in flight is ignored.
    exp_flight(0, 0, 0);
    exp_result(1, 0, 1, 1);
    exp_ready(1, 0, 1);
    kick(1'b0);
    press(32'h2800_0000);
    check("flight_enter_ignored", 32'(game_state), 32'd2);
    frames(29);
    check("flight_before_30th", 32'(game_state), 32'd2);
    frame(1'b0);
    check("goal_after_30th", 32'(game_state), 32'd3);
    frames(59);
    check("result_before_60th", 32'(game_state), 32'd3);
    frame(1'b0);
    check("ready_after_60th", 32'(game_state), 32'd1);

    // Kick 2: save on frame 10; the kicker stays high through RESULT and READY.
    exp_flight(1, 0, 1);
    exp_result(1, 1, 2, 0);
    exp_ready(1, 1, 2);
    kick(1'b1);
    frames(10);
    @(negedge clk_25MHz); save_detect = 1'b1;
    @(negedge clk_25MHz); save_detect = 1'b0;
    check("save_latency", 32'(game_state), 32'd3);
    frames(60);
    cycles(10);
    check("held_kick_ignored", 32'(game_state), 32'd1);
    player_at_ball_signal = 1'b0;
    cycles(3);

    // Kick 3: save_detect on the same cycle as the 30th tick counts as a save.
    exp_flight(1, 1, 2);
    exp_result(1, 2, 3, 0);
    exp_ready(1, 2, 3);
    kick(1'b0);
    frames(29);
    frame(1'b1);
    check("tie_is_save", {24'd0, goals, saves}, 32'h12);
    frames(60);

    // Kick 4: goal, then kick 5 is cut short by a reset in flight.
    exp_flight(1, 2, 3);
    exp_result(2, 2, 4, 1);
    exp_ready(2, 2, 4);
    exp_flight(2, 2, 4);
    exp_idle();
    kick(1'b0);
    frames(90);
    kick(1'b0);
    frames(5);
    check("goals_before_reset", 32'(goals), 32'd2);
    @(negedge clk_25MHz); reset_al = 1'b0;
    @(negedge clk_25MHz);
    check("reset_midgame_goals", 32'(goals), 32'd0);
    check("reset_midgame_state", 32'(game_state), 32'd0);
    cycles(3);
    reset_al = 1'b1;
    cycles(3);

    // Game 2: three straight goals end the game early.
    exp_ready(0, 0, 0);
    press(32'h0000_2800);
    for (int i = 0; i < 3; i++) begin
      exp_flight(i, 0, i);
      exp_result(i + 1, 0, i + 1, 1);
      if (i < 2) exp_ready(i + 1, 0, i + 1);
      else       exp_over(3, 0, 3, 1);
      kick(1'b0);
      frames(90);
    end
    check("early_over_state", 32'(game_state), 32'd4);
    check("early_over_kicks", 32'(kick_num), 32'd3);
    check("early_over_wins", 32'(shooter_wins), 32'd1);

    // Enter in OVER returns to IDLE; a second Enter starts a clean game.
    exp_idle();
    exp_ready(0, 0, 0);
    press(32'h0028_0000);
    check("over_to_idle", 32'(game_state), 32'd0);
    cycles(2);
    press(32'h0000_0028);
    check("restart_scores", {20'd0, goals, saves, kick_num}, 32'd0);
    cycles(5);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    finish_run();
  end

endmodule

// File: doc/penalty_shootout_fsm.md
# penalty_shootout_fsm

Game-control stage directly downstream of `color_mapper`. It consumes the `player_at_ball_signal` and `save_detect` outputs, the USB keycode word and `vsync`, and runs a best-of-N penalty shootout: start/restart, kick, save-or-goal resolution, result hold and early termination. Its registered score, kick index and state outputs drive the HUD/scoreboard rendering and the reset/respawn of sprites in `color_mapper`.

## Interface
- `NUM_KICKS`, 5: kicks per game; must be odd, range 1–15.
- `FLIGHT_FRAMES`, 30: frames a kick stays in flight before it counts as a goal.
- `RESULT_FRAMES`, 60: frames the goal/save result is held before the next kick.
- `clk_25MHz` input 1: single clock; all logic is on the rising edge.
- `reset_al` input 1: synchronous, active-low reset.
- `vsync` input 1: VGA vsync, synchronous to `clk_25MHz`; a rising edge is one frame tick.
- `keycode` input 32: four USB keycode bytes; Enter is 8'h28 in any byte.
- `player_at_ball_signal` input 1: from `color_mapper`; its rising edge is a kick.
- `save_detect` input 1: from `color_mapper`; level, keeper touching ball.
- `game_state` output 3: encoded current state (package enum).
- `goals` output 4: goals scored this game.
- `saves` output 4: saves made this game.
- `kick_num` output 4: kicks completed this game.
- `last_was_goal` output 1: outcome of the most recent kick; valid in RESULT.
- `kick_active` output 1: high while in FLIGHT.
- `respawn` output 1: one-cycle pulse when a new kick becomes available (entry to READY).
- `game_over` output 1: high in OVER.
- `shooter_wins` output 1: valid in OVER; 1 if goals > saves.

## Operation
- States: IDLE(0), READY(1), FLIGHT(2), RESULT(3), OVER(4).
- `enter` = any `keycode` byte equals 8'h28; it is edge-detected, so a held key acts once.
- `frame_tick` = registered vsync rising edge.
- `kick` = registered `player_at_ball_signal` rising edge.
- IDLE:
  - `enter` → READY.
  - Clears `goals`, `saves`, `kick_num` and `last_was_goal`.
  - Pulses `respawn`.
- READY:
  - `kick` → FLIGHT.
  - Frame counter cleared.
- FLIGHT:
  - Frame counter increments on each `frame_tick`.
  - `save_detect` high on any cycle → save: `saves`+1, `last_was_goal`=0, → RESULT.
  - Counter reaches FLIGHT_FRAMES with no save → goal: `goals`+1, `last_was_goal`=1, → RESULT.
  - Save and timeout in the same cycle → save wins.
  - `kick_num`+1 on either outcome.
- RESULT:
  - Held for RESULT_FRAMES frame ticks.
  - Then → OVER if `kick_num`==NUM_KICKS, or `goals` > NUM_KICKS/2, or `saves` > NUM_KICKS/2 (integer division).
  - Otherwise → READY with a `respawn` pulse.
- OVER:
  - `game_over`=1; `shooter_wins` = (`goals` > `saves`).
  - `enter` → IDLE.
- Ignored inputs:
  - `enter` outside IDLE and OVER.
  - `kick` outside READY.
  - `save_detect` outside FLIGHT.
- Counter widths:
  - Frame counter is $clog2(max(FLIGHT_FRAMES, RESULT_FRAMES)+1) bits.
  - Score counters saturate at 15; they cannot overflow with legal NUM_KICKS.

## Timing
- Reset (`reset_al`=0 at a clock edge) is synchronous:
  - State goes to IDLE; all counters go to 0.
  - All outputs 0, including `respawn` and `game_over`.
  - Edge-detect history registers go to 0.
- Reset mid-game discards scores. After release, the first vsync high does not produce a tick unless it is a true 0→1 edge.
- Edge detect adds one cycle: an input rising at edge t is seen as an event at t+1, and the state changes at t+2.
- `save_detect` is not edge-detected. The state changes on the edge after it is sampled high, so latency is 1 cycle.
- All outputs are registered and reflect the state and counters after the same edge; there is no combinational input-to-output path.
- A FLIGHT timeout takes exactly FLIGHT_FRAMES frame ticks after FLIGHT entry.
- `respawn` is high for exactly one cycle per READY entry.

## Structure
- `shootout_pkg` holds:
  - the `shootout_state_t` enum (3-bit);
  - `KEY_ENTER` = 8'h28;
  - the `game_state` encoding shared with `color_mapper` and the HUD.
- One sub-module, `rise_detect`: parameterised width, clock/reset, registered input with rising-edge pulse output. It is instantiated for `vsync`, `enter` and `player_at_ball_signal`.
- The FSM, frame counter and score registers live in the top module.

## Test plan
- Reset/start:
  - Hold `reset_al`=0 for 5 cycles → all outputs 0, `game_state`=0.
  - `keycode`=32'h00000028 for 1 cycle → READY within 2 cycles, one `respawn` pulse, scores 0.
- Goal:
  - In READY, raise `player_at_ball_signal`, then give 30 vsync pulses with `save_detect`=0 → RESULT, `goals`=1, `kick_num`=1, `last_was_goal`=1.
  - After 60 more frames → READY, `respawn` pulse.
- Save, including a tie with timeout:
  - Assert `save_detect` on frame 10 of a kick → `saves`+1, `last_was_goal`=0.
  - Assert `save_detect` on the cycle of the 30th tick → counted as a save, not a goal.
- Early termination:
  - Three consecutive goals with NUM_KICKS=5 → OVER after the third RESULT hold; `kick_num`=3, `shooter_wins`=1.
- Ignored inputs:
  - `enter` (32'h28000000, top byte) during FLIGHT → no state change.
  - `player_at_ball_signal` held high through RESULT → no extra kick on READY entry.
  - `save_detect` in READY → no score change.
- Mid-game reset and restart:
  - `reset_al`=0 during FLIGHT with `goals`=2 → IDLE, `goals`=0 next cycle.
  - `enter` in OVER → IDLE; a second `enter` → READY with cleared scores.
